countdown_ctrl: RTL and testbench

//  Sequencer for the keypad-driven countdown timer. Decodes keypad key events into

---
 rtl/countdown_ctrl_if.sv | 41 ++++
 rtl/countdown_ctrl.sv | 165 ++++++++++++++++
 tb/tb_countdown_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/countdown_ctrl_if.sv
// rtl/countdown_ctrl_if.sv - keypad, clock-block and display signal bundle for countdown_ctrl
//
// Purpose: groups every countdown_ctrl signal except clk/rst.
// Signals (direction as seen by the controller, modport slave):
//   tick        in   1  one-cycle strobe per timer second
//   key_valid   in   1  one-cycle strobe per key press
//   key         in   4  key code: 0-9 digits, 10 '*', 11 '#'
//   minute      in   7  clock block minutes
//   second      in   6  clock block seconds
//   load        out  1  load request to clock block
//   load_minute out  7  minutes to load
//   pause       out  1  freeze clock block
//   switch      out  1  controlled load, high while counting
//   disp_sel    out  1  0 = timer, 1 = entry buffer
//   entry       out  7  entry buffer
//   disp_en     out  1  display enable, blinks during alarm
// The master modport is the driving side (keypad/clock/display or a testbench).
interface countdown_ctrl_if;
    logic       tick;
    logic       key_valid;
    logic [3:0] key;
    logic [6:0] minute;
    logic [5:0] second;
    logic       load;
    logic [6:0] load_minute;
    logic       pause;
    logic       switch;
    logic       disp_sel;
    logic [6:0] entry;
    logic       disp_en;

    modport master (
        output tick, key_valid, key, minute, second,
        input  load, load_minute, pause, switch, disp_sel, entry, disp_en
    );

    modport slave (
        input  tick, key_valid, key, minute, second,
        output load, load_minute, pause, switch, disp_sel, entry, disp_en
    );
endinterface

// File: rtl/countdown_ctrl.sv
// rtl/countdown_ctrl.sv - keypad-driven countdown timer sequencer
//
// Purpose: decodes key events into entry/start/pause/abort, drives the clock
// block load/pause/load_minute, detects expiry, drives switch and display
// select/blink.
// Ports:
//   clk  in  1  system clock
//   rst  in  1  synchronous active-high reset
//   bus  countdown_ctrl_if.slave (tick, key_valid, key, minute, second in;
//        load, load_minute, pause, switch, disp_sel, entry, disp_en out)
// All outputs come straight from flops; key/tick effects appear one cycle
// after the strobe.
module countdown_ctrl #(
    parameter logic [6:0] DEFAULT_MIN = 7'd1,
    parameter logic [6:0] MAX_MIN     = 7'd99,
    parameter logic [3:0] ALARM_SECS  = 4'd10
) (
    input  logic            clk,
    input  logic            rst,
    countdown_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_LOADING,
        S_RUN,
        S_PAUSED,
        S_EXPIRED
    } state_t;

    state_t     state, state_nxt;
    logic [6:0] preset, preset_nxt;
    logic [6:0] entry_q, entry_nxt;
    logic [3:0] alarm_cnt, alarm_cnt_nxt;
    logic       blink, blink_nxt;
    logic       load_q, load_nxt;
    logic       pause_q, pause_nxt;
    logic       switch_q, switch_nxt;
    logic       disp_sel_q, disp_sel_nxt;

    logic       key_digit, key_star, key_hash, key_any;
    logic [6:0] entry_shift, entry_clamped;
    logic [3:0] alarm_inc;
    logic       timer_zero, load_done;

    assign key_digit = bus.key_valid && (bus.key <= 4'd9);
    assign key_star  = bus.key_valid && (bus.key == 4'd10);
    assign key_hash  = bus.key_valid && (bus.key == 4'd11);
    assign key_any   = bus.key_valid && (bus.key <= 4'd11);

    // Two-digit shift register in decimal: keep the last digit, append the new one.
    assign entry_shift   = 7'((entry_q % 7'd10) * 7'd10) + {3'd0, bus.key};
    assign entry_clamped = (entry_shift > MAX_MIN) ? MAX_MIN : entry_shift;

    assign alarm_inc  = alarm_cnt + 4'd1;
    assign timer_zero = (bus.minute == 7'd0) && (bus.second == 6'd0);
    assign load_done  = (bus.minute == preset) && (bus.second == 6'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            preset     <= DEFAULT_MIN;
            entry_q    <= 7'd0;
            alarm_cnt  <= 4'd0;
            blink      <= 1'b1;
            load_q     <= 1'b0;
            pause_q    <= 1'b1;
            switch_q   <= 1'b0;
            disp_sel_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            preset     <= preset_nxt;
            entry_q    <= entry_nxt;
            alarm_cnt  <= alarm_cnt_nxt;
            blink      <= blink_nxt;
            load_q     <= load_nxt;
            pause_q    <= pause_nxt;
            switch_q   <= switch_nxt;
            disp_sel_q <= disp_sel_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        preset_nxt    = preset;
        entry_nxt     = entry_q;
        alarm_cnt_nxt = alarm_cnt;
        blink_nxt     = 1'b1;
        unique case (state)
            S_IDLE: begin
                if (key_digit) begin
                    entry_nxt = {3'd0, bus.key};
                    state_nxt = S_ENTRY;
                end else if (key_hash && (preset != 7'd0)) begin
                    state_nxt = S_LOADING;
                end
            end
            S_ENTRY: begin
                if (key_digit) begin
                    entry_nxt = entry_clamped;
                end else if (key_hash && (entry_q != 7'd0)) begin
                    preset_nxt = entry_q;
                    state_nxt  = S_LOADING;
                end else if (key_star) begin
                    entry_nxt = 7'd0;
                    state_nxt = S_IDLE;
                end
            end
            S_LOADING: begin
                // Abort takes precedence over a load completing in the same cycle.
                if (key_star) begin
                    state_nxt = S_IDLE;
                end else if (load_done) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (timer_zero) begin
                    alarm_cnt_nxt = 4'd0;
                    state_nxt     = S_EXPIRED;
                end else if (key_hash) begin
                    state_nxt = S_PAUSED;
                end else if (key_star) begin
                    state_nxt = S_IDLE;
                end
            end
            S_PAUSED: begin
                if (key_hash) begin
                    state_nxt = S_RUN;
                end else if (key_star) begin
                    state_nxt = S_IDLE;
                end
            end
            S_EXPIRED: begin
                blink_nxt = blink;
                if (bus.tick) begin
                    alarm_cnt_nxt = alarm_inc;
                    blink_nxt     = ~blink;
                end
                // Leaving the alarm always restores a lit display.
                if (key_any || (bus.tick && (alarm_inc == ALARM_SECS))) begin
                    blink_nxt = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they land in flops together with it.
    always_comb begin
        load_nxt     = (state_nxt == S_LOADING);
        pause_nxt    = !((state_nxt == S_LOADING) || (state_nxt == S_RUN));
        switch_nxt   = (state_nxt == S_RUN);
        disp_sel_nxt = (state_nxt == S_ENTRY);
    end

    assign bus.load        = load_q;
    assign bus.load_minute = preset;
    assign bus.pause       = pause_q;
    assign bus.switch      = switch_q;
    assign bus.disp_sel    = disp_sel_q;
    assign bus.entry       = entry_q;
    assign bus.disp_en     = blink;
endmodule

// File: tb/tb_countdown_ctrl.sv
// tb/tb_countdown_ctrl.sv - self-checking bench for countdown_ctrl
module tb_countdown_ctrl;
    localparam int DEF_MIN = 1;
    localparam int MAX_MIN = 99;
    localparam int ALARM   = 10;

    localparam int M_IDLE = 0, M_ENTRY = 1, M_LOAD = 2, M_RUN = 3, M_PAUSED = 4, M_EXP = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    countdown_ctrl_if bus();

    countdown_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    int m_mode, m_preset, m_entry, m_alarm;
    bit m_blink;

    typedef struct {
        logic       kv;
        logic [3:0] key;
        logic [6:0] mn;
        logic [5:0] sc;
        logic [6:0] e_entry;
        logic       e_sel;
        logic       e_load;
        logic       e_switch;
        logic [6:0] e_lmin;
    } vec_t;

    vec_t vecs[13];

    task automatic expect_eq(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step(bit r, bit kv, int k, bit tk, int mn, int sc);
        bit dig, star, hash, valid;
        int v;
        dig   = kv && (k <= 9);
        star  = kv && (k == 10);
        hash  = kv && (k == 11);
        valid = kv && (k <= 11);
        if (r) begin
            m_mode = M_IDLE; m_preset = DEF_MIN; m_entry = 0; m_alarm = 0; m_blink = 1'b1;
            return;
        end
        case (m_mode)
            M_IDLE:
                if (dig) begin m_entry = k; m_mode = M_ENTRY; end
                else if (hash && m_preset != 0) m_mode = M_LOAD;
            M_ENTRY:
                if (dig) begin
                    v = (m_entry % 10) * 10 + k;
                    m_entry = (v > MAX_MIN) ? MAX_MIN : v;
                end else if (hash && m_entry != 0) begin
                    m_preset = m_entry; m_mode = M_LOAD;
                end else if (star) begin
                    m_entry = 0; m_mode = M_IDLE;
                end
            M_LOAD:
                if (star) m_mode = M_IDLE;
                else if (mn == m_preset && sc == 0) m_mode = M_RUN;
            M_RUN:
                if (mn == 0 && sc == 0) begin m_mode = M_EXP; m_alarm = 0; m_blink = 1'b1; end
                else if (hash) m_mode = M_PAUSED;
                else if (star) m_mode = M_IDLE;
            M_PAUSED:
                if (hash) m_mode = M_RUN;
                else if (star) m_mode = M_IDLE;
            default: begin
                if (tk) begin m_alarm++; m_blink = !m_blink; end
                if (valid || m_alarm == ALARM) begin m_mode = M_IDLE; m_blink = 1'b1; end
            end
        endcase
    endfunction

    task automatic check_model();
        expect_eq("mdl_load",     bus.load,        m_mode == M_LOAD);
        expect_eq("mdl_pause",    bus.pause,       !(m_mode == M_LOAD || m_mode == M_RUN));
        expect_eq("mdl_switch",   bus.switch,      m_mode == M_RUN);
        expect_eq("mdl_disp_sel", bus.disp_sel,    m_mode == M_ENTRY);
        expect_eq("mdl_entry",    bus.entry,       m_entry);
        expect_eq("mdl_lmin",     bus.load_minute, m_preset);
        expect_eq("mdl_disp_en",  bus.disp_en,     (m_mode == M_EXP) ? m_blink : 1'b1);
    endtask

    task automatic drive(bit r, bit kv, logic [3:0] k, bit tk, logic [6:0] mn, logic [5:0] sc);
        rst           = r;
        bus.key_valid = kv;
        bus.key       = k;
        bus.tick      = tk;
        bus.minute    = mn;
        bus.second    = sc;
        @(posedge clk);
        #1;
        model_step(r, kv, int'(k), tk, int'(mn), int'(sc));
        check_model();
    endtask

    task automatic key_in(logic [3:0] k, logic [6:0] mn, logic [5:0] sc);
        drive(1'b0, 1'b1, k, 1'b0, mn, sc);
    endtask

    task automatic idle(logic [6:0] mn, logic [5:0] sc);
        drive(1'b0, 1'b0, 4'd0, 1'b0, mn, sc);
    endtask

    initial begin
        bit exp_de;
        logic [6:0] rmn;
        logic [5:0] rsc;

        vecs[0]  = '{1'b1, 4'd9,  7'd0,  6'd0, 7'd9,  1'b1, 1'b0, 1'b0, 7'd1};
        vecs[1]  = '{1'b1, 4'd9,  7'd0,  6'd0, 7'd99, 1'b1, 1'b0, 1'b0, 7'd1};
        vecs[2]  = '{1'b1, 4'd9,  7'd0,  6'd0, 7'd99, 1'b1, 1'b0, 1'b0, 7'd1};
        vecs[3]  = '{1'b1, 4'd10, 7'd0,  6'd0, 7'd0,  1'b0, 1'b0, 1'b0, 7'd1};
        vecs[4]  = '{1'b1, 4'd1,  7'd0,  6'd0, 7'd1,  1'b1, 1'b0, 1'b0, 7'd1};
        vecs[5]  = '{1'b1, 4'd2,  7'd0,  6'd0, 7'd12, 1'b1, 1'b0, 1'b0, 7'd1};
        vecs[6]  = '{1'b1, 4'd3,  7'd0,  6'd0, 7'd23, 1'b1, 1'b0, 1'b0, 7'd1};
        vecs[7]  = '{1'b1, 4'd15, 7'd0,  6'd0, 7'd23, 1'b1, 1'b0, 1'b0, 7'd1};
        vecs[8]  = '{1'b1, 4'd10, 7'd0,  6'd0, 7'd0,  1'b0, 1'b0, 1'b0, 7'd1};
        vecs[9]  = '{1'b1, 4'd4,  7'd0,  6'd0, 7'd4,  1'b1, 1'b0, 1'b0, 7'd1};
        vecs[10] = '{1'b1, 4'd5,  7'd0,  6'd0, 7'd45, 1'b1, 1'b0, 1'b0, 7'd1};
        vecs[11] = '{1'b1, 4'd11, 7'd0,  6'd0, 7'd45, 1'b0, 1'b1, 1'b0, 7'd45};
        vecs[12] = '{1'b0, 4'd0,  7'd45, 6'd0, 7'd45, 1'b0, 1'b0, 1'b1, 7'd45};

        bus.key_valid = 1'b0; bus.key = 4'd0; bus.tick = 1'b0;
        bus.minute = 7'd0; bus.second = 6'd0;

        // Reset state
        drive(1'b1, 1'b0, 4'd0, 1'b0, 7'd0, 6'd0);
        drive(1'b1, 1'b0, 4'd0, 1'b0, 7'd0, 6'd0);
        expect_eq("rst_load",  bus.load, 0);
        expect_eq("rst_pause", bus.pause, 1);
        expect_eq("rst_switch", bus.switch, 0);
        expect_eq("rst_sel",   bus.disp_sel, 0);
        expect_eq("rst_den",   bus.disp_en, 1);
        expect_eq("rst_lmin",  bus.load_minute, 1);
        expect_eq("rst_entry", bus.entry, 0);

        // Entry table
        for (int i = 0; i < 13; i++) begin
            drive(1'b0, vecs[i].kv, vecs[i].key, 1'b0, vecs[i].mn, vecs[i].sc);
            expect_eq($sformatf("tbl%0d_entry", i),  bus.entry,       vecs[i].e_entry);
            expect_eq($sformatf("tbl%0d_sel", i),    bus.disp_sel,    vecs[i].e_sel);
            expect_eq($sformatf("tbl%0d_load", i),   bus.load,        vecs[i].e_load);
            expect_eq($sformatf("tbl%0d_switch", i), bus.switch,      vecs[i].e_switch);
            expect_eq($sformatf("tbl%0d_lmin", i),   bus.load_minute, vecs[i].e_lmin);
        end

        // Default preset load, pause/resume/abort
        drive(1'b1, 1'b0, 4'd0, 1'b0, 7'd0, 6'd0);
        key_in(4'd11, 7'd0, 6'd0);
        expect_eq("ld_load", bus.load, 1);
        expect_eq("ld_pause", bus.pause, 0);
        idle(7'd0, 6'd0);
        expect_eq("ld_hold", bus.load, 1);
        idle(7'd1, 6'd0);
        expect_eq("run_load", bus.load, 0);
        expect_eq("run_switch", bus.switch, 1);
        expect_eq("run_pause", bus.pause, 0);
        key_in(4'd13, 7'd0, 6'd59);
        expect_eq("run_badkey", bus.switch, 1);
        key_in(4'd11, 7'd0, 6'd58);
        expect_eq("pau_pause", bus.pause, 1);
        expect_eq("pau_switch", bus.switch, 0);
        key_in(4'd11, 7'd0, 6'd58);
        expect_eq("res_switch", bus.switch, 1);
        key_in(4'd10, 7'd0, 6'd57);
        expect_eq("abort_switch", bus.switch, 0);
        expect_eq("abort_lmin", bus.load_minute, 1);

        // Expiry beats '#', then ten-tick alarm
        key_in(4'd11, 7'd1, 6'd0);
        idle(7'd1, 6'd0);
        expect_eq("run2_switch", bus.switch, 1);
        key_in(4'd11, 7'd0, 6'd0);
        expect_eq("exp_switch", bus.switch, 0);
        expect_eq("exp_pause", bus.pause, 1);
        expect_eq("exp_den", bus.disp_en, 1);
        exp_de = 1'b1;
        for (int i = 0; i < ALARM; i++) begin
            drive(1'b0, 1'b0, 4'd0, 1'b1, 7'd0, 6'd0);
            exp_de = !exp_de;
            expect_eq($sformatf("alarm_tick%0d", i), bus.disp_en, exp_de);
            if (i == 4) key_in(4'd14, 7'd0, 6'd0);
            else idle(7'd0, 6'd0);
            expect_eq($sformatf("alarm_hold%0d", i), bus.disp_en, exp_de);
        end
        drive(1'b0, 1'b0, 4'd0, 1'b1, 7'd0, 6'd0);
        expect_eq("post_alarm_den", bus.disp_en, 1);
        key_in(4'd11, 7'd0, 6'd0);
        expect_eq("post_alarm_idle", bus.load, 1);

        // Key coinciding with the final alarm tick
        idle(7'd1, 6'd0);
        idle(7'd0, 6'd0);
        for (int i = 0; i < ALARM - 1; i++) drive(1'b0, 1'b0, 4'd0, 1'b1, 7'd0, 6'd0);
        expect_eq("pre_final_den", bus.disp_en, 0);
        drive(1'b0, 1'b1, 4'd5, 1'b1, 7'd0, 6'd0);
        expect_eq("final_den", bus.disp_en, 1);
        expect_eq("final_sel", bus.disp_sel, 0);
        key_in(4'd11, 7'd0, 6'd0);
        expect_eq("final_idle", bus.load, 1);

        // Reset mid-RUN
        key_in(4'd10, 7'd0, 6'd0);
        key_in(4'd3, 7'd0, 6'd0);
        key_in(4'd11, 7'd0, 6'd0);
        expect_eq("p3_lmin", bus.load_minute, 3);
        idle(7'd3, 6'd0);
        expect_eq("p3_switch", bus.switch, 1);
        drive(1'b1, 1'b0, 4'd0, 1'b0, 7'd2, 6'd30);
        expect_eq("mrst_switch", bus.switch, 0);
        expect_eq("mrst_pause", bus.pause, 1);
        expect_eq("mrst_lmin", bus.load_minute, 1);
        expect_eq("mrst_entry", bus.entry, 0);

        // Randomized run against the reference model
        rmn = 7'd0;
        for (int i = 0; i < 3000; i++) begin
            bit r, kv, tk;
            logic [3:0] k;
            r  = ($urandom_range(0, 63) == 0);
            kv = ($urandom_range(0, 3) == 0);
            k  = ($urandom_range(0, 2) == 0) ? 4'd11 : 4'($urandom_range(0, 15));
            tk = ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 3))
                0: rmn = 7'(m_preset);
                1: rmn = 7'd0;
                2: rmn = 7'($urandom_range(0, 99));
                default: ;
            endcase
            rsc = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(0, 59)) : 6'd0;
            drive(r, kv, k, tk, rmn, rsc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
